// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: frame start marker and FSM state encoding.
package loader_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LENGTH,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_packer.sv
// byte_packer: assembles BYTES_PER_WORD bytes, MSB first, into one instruction word.
module byte_packer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int BYTES_PER_WORD    = INSTRUCTION_WIDTH / 8
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         clear,
  input  logic                         byteStrobe,
  input  logic [7:0]                   byteData,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         wordReady
);

  localparam int COUNT_WIDTH = $clog2(BYTES_PER_WORD + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_BYTE = COUNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [COUNT_WIDTH-1:0]       byteCount;
  logic [INSTRUCTION_WIDTH-1:0] shiftReg;
  logic [INSTRUCTION_WIDTH+7:0] extended;

  // The word includes the incoming byte so the owner can register it on the same edge.
  assign extended  = {shiftReg, byteData};
  assign word      = extended[INSTRUCTION_WIDTH-1:0];
  assign wordReady = byteStrobe && (byteCount == LAST_BYTE);

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      byteCount <= '0;
      shiftReg  <= '0;
    end else if (clear) begin
      byteCount <= '0;
      shiftReg  <= '0;
    end else if (byteStrobe) begin
      shiftReg  <= word;
      byteCount <= wordReady ? '0 : byteCount + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed program image from a byte stream into instruction memory,
// holding the CPU in reset until a complete, verified image is in place.
module program_loader
  import loader_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 8,
  localparam int BYTES_PER_WORD   = INSTRUCTION_WIDTH / 8
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         byteValid,
  input  logic [7:0]                   byteData,
  output logic                         byteReady,
  input  logic                         reload,
  output logic                         memWriteEnable,
  output logic [PC_WIDTH-1:0]          memAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError,
  output loader_state_t                debugState
);

  localparam logic [PC_WIDTH-1:0] ONE_ADDR = PC_WIDTH'(1);

  // Handshake: a byte moves only on a clock edge where byteValid && byteReady;
  // the host holds byteData stable until then.
  loader_state_t                state, nextState;
  logic [PC_WIDTH-1:0]          lenReg, wordCount;
  logic [7:0]                   checksum;
  logic                         byteAccept, latchLen, clearSum, packerStrobe, writeWord, lastWord;
  logic [INSTRUCTION_WIDTH-1:0] packedWord;
  logic                         wordReady;

  assign byteAccept = byteValid && byteReady;
  // LEN = 0 maps naturally to a full 2^PC_WIDTH-word image through the wrap.
  assign lastWord   = (wordCount == lenReg - ONE_ADDR);
  assign writeWord  = packerStrobe && wordReady;

  byte_packer #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH),
    .BYTES_PER_WORD   (BYTES_PER_WORD)
  ) packer (
    .clock     (clock),
    .isReset   (isReset),
    .clear     (latchLen),
    .byteStrobe(packerStrobe),
    .byteData  (byteData),
    .word      (packedWord),
    .wordReady (wordReady)
  );

  always_comb begin
    nextState    = state;
    latchLen     = 1'b0;
    clearSum     = 1'b0;
    packerStrobe = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (byteAccept && byteData == START_BYTE) begin
          nextState = LENGTH;
          clearSum  = 1'b1;
        end
      end
      LENGTH: begin
        if (byteAccept) begin
          latchLen  = 1'b1;
          nextState = DATA;
        end
      end
      DATA: begin
        if (byteAccept) begin
          packerStrobe = 1'b1;
          if (wordReady && lastWord) nextState = CHECK;
        end
      end
      CHECK: begin
        if (byteAccept) nextState = (byteData == checksum) ? DONE : ERROR;
      end
      DONE: begin
        if (reload) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state          <= IDLE;
      byteReady      <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memData        <= '0;
      lenReg         <= '0;
      wordCount      <= '0;
      checksum       <= '0;
    end else begin
      state          <= nextState;
      byteReady      <= (nextState != DONE);
      memWriteEnable <= writeWord;
      if (latchLen) begin
        lenReg    <= PC_WIDTH'(byteData);
        wordCount <= '0;
      end else if (writeWord) begin
        memAddress <= wordCount;
        memData    <= packedWord;
        wordCount  <= wordCount + ONE_ADDR;
      end
      if (clearSum) checksum <= '0;
      else if (packerStrobe) checksum <= checksum ^ byteData;
    end
  end

  assign cpuHold    = (state != DONE);
  assign loadDone   = (state == DONE);
  assign loadError  = (state == ERROR);
  assign debugState = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven frames, hand-written corner sequences,
// randomized frames against a frame-level reference model.
module tb_program_loader;
  import loader_pkg::*;

  localparam int IW = 32;
  localparam int PW = 8;

  logic          clock = 1'b0;
  logic          isReset = 1'b1;
  logic          byteValid = 1'b0;
  logic [7:0]    byteData = 8'h00;
  logic          reload = 1'b0;
  logic          byteReady, memWriteEnable, cpuHold, loadDone, loadError;
  logic [PW-1:0] memAddress;
  logic [IW-1:0] memData;
  loader_state_t debugState;

  program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clock         (clock),
    .isReset       (isReset),
    .byteValid     (byteValid),
    .byteData      (byteData),
    .byteReady     (byteReady),
    .reload        (reload),
    .memWriteEnable(memWriteEnable),
    .memAddress    (memAddress),
    .memData       (memData),
    .cpuHold       (cpuHold),
    .loadDone      (loadDone),
    .loadError     (loadError),
    .debugState    (debugState)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int writeCount = 0;
  bit pendingWrite = 1'b0;
  logic [PW+IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (pendingWrite) begin
      check("write_latency", 64'(memWriteEnable), 64'd1);
      pendingWrite = 1'b0;
    end
    if (memWriteEnable === 1'b1) begin
      writeCount++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", memAddress, memData);
      end else begin
        check("write_addr_data", 64'({memAddress, memData}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    byteValid = 1'b1;
    byteData  = b;
    while (byteReady !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (byteReady !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byteReady=%0b, required 1", byteReady);
      byteValid = 1'b0;
      return;
    end
    @(posedge clock);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clock);
      byteValid = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [31:0] base;
    logic [31:0] step;
    bit          forceSum;
    logic [7:0]  sumValue;
    bit          garbage;
    bit          expDone;
  } frame_t;

  // Reference model: the image is word i = base + i*step, written at address i,
  // and the frame passes only if the SUM sent equals the XOR of all payload bytes.
  task automatic sendFrame(input frame_t f, input bit bubbles, output bit modelDone);
    int nWords = (f.len == 0) ? (1 << PW) : int'(f.len);
    logic [7:0]  sum = 8'h00;
    logic [7:0]  sumSent;
    logic [31:0] word;
    logic [7:0]  b;
    sendByte(START_BYTE);
    sendByte(f.len);
    for (int w = 0; w < nWords; w++) begin
      word = f.base + 32'(w) * f.step;
      for (int k = 0; k < 4; k++) begin
        b = word[31 - 8*k -: 8];
        sum ^= b;
        if (bubbles && $urandom_range(0, 3) == 0) idleCycles(1);
        sendByte(b);
        if (k == 3) begin
          exp_q.push_back({PW'(w), word});
          pendingWrite = 1'b1;
        end
      end
    end
    sumSent = f.forceSum ? f.sumValue : sum;
    sendByte(sumSent);
    modelDone = (sumSent == sum);
  endtask

  task automatic checkStatus(input string tag, input bit expDone);
    @(negedge clock);
    byteValid = 1'b0;
    check({tag, "_loadDone"},  64'(loadDone),  64'(expDone));
    check({tag, "_loadError"}, 64'(loadError), 64'(!expDone));
    check({tag, "_cpuHold"},   64'(cpuHold),   64'(!expDone));
    check({tag, "_byteReady"}, 64'(byteReady), 64'(!expDone));
    check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic doReload(input string tag);
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload    = 1'b0;
    byteValid = 1'b0;
    check({tag, "_reload_cpuHold"},   64'(cpuHold),   64'd1);
    check({tag, "_reload_byteReady"}, 64'(byteReady), 64'd1);
    check({tag, "_reload_loadDone"},  64'(loadDone),  64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_cpuHold"},   64'(cpuHold),        64'd1);
    check({tag, "_loadDone"},  64'(loadDone),       64'd0);
    check({tag, "_loadError"}, 64'(loadError),      64'd0);
    check({tag, "_memWE"},     64'(memWriteEnable), 64'd0);
    check({tag, "_memAddr"},   64'(memAddress),     64'd0);
    check({tag, "_memData"},   64'(memData),        64'd0);
    check({tag, "_byteReady"}, 64'(byteReady),      64'd0);
    check({tag, "_state"},     64'(debugState),     64'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  frame_t vecs[4];
  frame_t f;
  bit     modelDone;
  int     writesBefore;
  logic [7:0] g;

  initial begin
    vecs[0] = '{len: 8'd2, base: 32'h11223344, step: 32'h44444444, forceSum: 1'b0, sumValue: 8'h00, garbage: 1'b0, expDone: 1'b1};
    vecs[1] = '{len: 8'd1, base: 32'hDEADBEEF, step: 32'h0,        forceSum: 1'b0, sumValue: 8'h00, garbage: 1'b1, expDone: 1'b1};
    vecs[2] = '{len: 8'd2, base: 32'h11223344, step: 32'h44444444, forceSum: 1'b1, sumValue: 8'h00, garbage: 1'b0, expDone: 1'b0};
    vecs[3] = '{len: 8'd3, base: 32'h01020304, step: 32'h01010101, forceSum: 1'b0, sumValue: 8'h00, garbage: 1'b0, expDone: 1'b1};

    // Reset state, then byteReady rises the first cycle after release.
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    isReset = 1'b0;
    @(negedge clock);
    check("reset_release_byteReady", 64'(byteReady), 64'd1);

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].garbage) begin
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
      end
      sendFrame(vecs[i], 1'b0, modelDone);
      checkStatus($sformatf("vec%0d", i), vecs[i].expDone);
      if (vecs[i].expDone) doReload($sformatf("vec%0d", i));
      else begin
        // reload outside DONE has no effect
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        check("error_reload_ignored_loadError", 64'(loadError), 64'd1);
        check("error_reload_ignored_cpuHold",   64'(cpuHold),   64'd1);
      end
    end

    // DONE ignores a held byteValid; reload re-arms the next cycle.
    f = '{len: 8'd1, base: 32'hCAFEF00D, step: 32'h0, forceSum: 1'b0, sumValue: 8'h00, garbage: 1'b0, expDone: 1'b1};
    sendFrame(f, 1'b0, modelDone);
    checkStatus("hold", 1'b1);
    byteValid = 1'b1;
    byteData  = START_BYTE;
    repeat (4) begin
      @(negedge clock);
      check("hold_byteReady_low", 64'(byteReady), 64'd0);
      check("hold_still_done",    64'(loadDone),  64'd1);
    end
    doReload("hold");
    check("hold_state_idle", 64'(debugState), 64'(IDLE));

    // LEN = 0: full 256-word image, no wrap write.
    writesBefore = writeCount;
    f = '{len: 8'd0, base: 32'h0, step: 32'h1, forceSum: 1'b0, sumValue: 8'h00, garbage: 1'b0, expDone: 1'b1};
    sendFrame(f, 1'b0, modelDone);
    checkStatus("len0", 1'b1);
    check("len0_write_count", 64'(writeCount - writesBefore), 64'd256);
    doReload("len0");

    // Reset after 5 payload bytes aborts immediately.
    sendByte(START_BYTE);
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    sendByte(8'h44);
    exp_q.push_back({PW'(0), 32'h11223344});
    pendingWrite = 1'b1;
    sendByte(8'h55);
    #2;
    isReset   = 1'b1;
    byteValid = 1'b0;
    #1;
    checkResetValues("midreset");
    writesBefore = writeCount;
    repeat (3) @(negedge clock);
    check("midreset_no_writes", 64'(writeCount - writesBefore), 64'd0);
    isReset = 1'b0;
    sendFrame(vecs[0], 1'b0, modelDone);
    checkStatus("after_reset", 1'b1);
    doReload("after_reset");

    // Randomized frames with garbage, bubbles and occasional bad checksums.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom_range(0, 255));
        if (g == START_BYTE) g = 8'h00;
        sendByte(g);
      end
      f.len      = 8'($urandom_range(1, 5));
      f.base     = $urandom;
      f.step     = $urandom;
      f.forceSum = ($urandom_range(0, 3) == 0);
      f.sumValue = 8'($urandom_range(0, 255));
      f.garbage  = 1'b0;
      f.expDone  = 1'b0;
      sendFrame(f, 1'b1, modelDone);
      checkStatus($sformatf("rand%0d", r), modelDone);
      if (modelDone) doReload($sformatf("rand%0d", r));
    end

    idleCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
